sp_ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of one single-port RAM (sync write, async read, `en` = write enable).
- After reset it runs an initialisation sweep that writes INIT_VALUE to every word.
- It then serves at most one read or write per cycle from two valid/ready request ports and returns read data one cycle after acceptance.
- Sits between two client blocks and the RAM instance; sole driver of the RAM's en/addr/din.

---
 rtl/sp_ram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sp_ram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: two-requester round-robin arbiter and sequencer in front of a
// single-port RAM (synchronous write, combinational read, ram_en = write enable).
//
// After reset the block sweeps every RAM word with INIT_VALUE, which takes DEPTH cycles.
// It then serves at most one access per cycle from the two request ports. Read data
// returns on rsp_rdata one cycle after acceptance, and the matching rsp_valid bit
// pulses for that one cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   req_valid  per-requester request valid (bit i = requester i)
//   req_ready  per-requester accept, one-hot or zero; depends combinationally on req_valid
//   req_we     per-requester 1 = write, 0 = read
//   req_addr   requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  requester i write data at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid  per-requester read-data valid pulse
//   rsp_rdata  read data, meaningful only while a rsp_valid bit is high
//   init_done  high once the init sweep has completed
//   ram_en     RAM write enable
//   ram_addr   RAM address
//   ram_din    RAM write data
//   ram_dout   RAM combinational read data
module sp_ram_arbiter #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DEPTH      = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_done,
  output logic                    ram_en,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StArb} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  ptr_q, ptr_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  grant_vld;
  logic                  grant_idx;
  logic [ADDR_WIDTH-1:0] addr_arr [2];
  logic [DATA_WIDTH-1:0] wdata_arr [2];

  assign addr_arr[0]  = req_addr[0 +: ADDR_WIDTH];
  assign addr_arr[1]  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata_arr[0] = req_wdata[0 +: DATA_WIDTH];
  assign wdata_arr[1] = req_wdata[DATA_WIDTH +: DATA_WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      ptr_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state logic: the sweep counter runs only in StInit; StArb is held until reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d     = StArb;
          init_done_d = 1'b1;
        end
      end
      StArb: begin
        init_done_d = 1'b1;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // Grant selection. On contention the pointer decides; a lone request always wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (state_q == StArb) begin
      unique case (req_valid)
        2'b01: begin
          grant_vld = 1'b1;
          grant_idx = 1'b0;
        end
        2'b10: begin
          grant_vld = 1'b1;
          grant_idx = 1'b1;
        end
        2'b11: begin
          grant_vld = 1'b1;
          grant_idx = ptr_q;
        end
        default: begin
          grant_vld = 1'b0;
          grant_idx = 1'b0;
        end
      endcase
    end
  end

  // Output logic: RAM drive, ready, and response/pointer next values.
  always_comb begin
    req_ready   = 2'b00;
    ram_en      = 1'b0;
    ram_addr    = '0;
    ram_din     = '0;
    ptr_d       = ptr_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    if (state_q == StInit) begin
      ram_en   = 1'b1;
      ram_addr = cnt_q[ADDR_WIDTH-1:0];
      ram_din  = INIT_VALUE;
    end else if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
      ram_addr             = addr_arr[grant_idx];
      ptr_d                = ~grant_idx;
      if (req_we[grant_idx]) begin
        ram_en  = 1'b1;
        ram_din = wdata_arr[grant_idx];
      end else begin
        // Combinational RAM read is captured now and presented next cycle.
        rsp_valid_d[grant_idx] = 1'b1;
        rsp_rdata_d            = ram_dout;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
module tb_sp_ram_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] INIT = 8'h00;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            init_done;
  logic            ram_en;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  sp_ram_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .INIT_VALUE (INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Single-port RAM: synchronous write, combinational read.
  logic [DW-1:0] ram [DEPTH];
  assign ram_dout = ram[ram_addr];
  always @(posedge clk) begin
    if (ram_en) ram[ram_addr] <= ram_din;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Remembers what the memory must hold, where the sweep is, who has priority and
  // which response is owed next cycle.
  bit            live = 0;
  int            sweep_idx;
  int            prio;
  logic [DW-1:0] mem [DEPTH];
  logic [1:0]    pend_v;
  logic [DW-1:0] pend_d;

  function automatic int pick(input logic [1:0] v, input int p);
    if (v == 2'b00) return -1;
    if (v == 2'b11) return p;
    return v[1] ? 1 : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        live      = 1;
        sweep_idx = 0;
        prio      = 0;
        pend_v    = 2'b00;
      end else if (live) begin
        if (sweep_idx < DEPTH) begin
          mem[sweep_idx] = INIT;
          sweep_idx++;
          pend_v = 2'b00;
        end else begin
          int g;
          logic [AW-1:0] a;
          g = pick(req_valid, prio);
          pend_v = 2'b00;
          if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            if (req_we[g]) begin
              mem[a] = req_wdata[g*DW +: DW];
            end else begin
              pend_v[g] = 1'b1;
              pend_d    = mem[a];
            end
            prio = 1 - g;
          end
        end
      end
    end
  end

  // Compare process, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        int            g;
        logic [1:0]    e_ready;
        logic          e_en;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        e_ready = 2'b00;
        e_en    = 1'b0;
        e_addr  = '0;
        e_din   = '0;
        if (sweep_idx < DEPTH) begin
          e_en   = 1'b1;
          e_addr = AW'(sweep_idx);
          e_din  = INIT;
        end else begin
          g = pick(req_valid, prio);
          if (g >= 0) begin
            e_ready[g] = 1'b1;
            e_en       = req_we[g];
            e_addr     = req_addr[g*AW +: AW];
            e_din      = req_wdata[g*DW +: DW];
          end
        end
        chk("m_ready", 32'(req_ready), 32'(e_ready));
        chk("m_ram_en", 32'(ram_en), 32'(e_en));
        chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
        if (e_en) chk("m_ram_din", 32'(ram_din), 32'(e_din));
        chk("m_init_done", 32'(init_done), 32'(sweep_idx >= DEPTH));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(pend_v));
        if (pend_v != 2'b00) chk("m_rsp_rdata", 32'(rsp_rdata), 32'(pend_d));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_we[i]            = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear();
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clear();
    tick();
    tick();
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_ram_en", 32'(ram_en), 1);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b1;
    repeat (15) tick();
    chk("sweep_last_addr", 32'(ram_addr), 15);
    chk("sweep_not_done", 32'(init_done), 0);
    tick();
    chk("sweep_done", 32'(init_done), 1);
    chk("idle_ram_en", 32'(ram_en), 0);

    // Every word reads back as INIT.
    for (int a = 0; a < DEPTH; a++) begin
      clear();
      set_req(0, 1, 0, AW'(a), 8'h00);
      tick();
      chk("init_rd_valid", 32'(rsp_valid), 32'h1);
      chk("init_rd_data", 32'(rsp_rdata), 32'(INIT));
    end
    clear();
    tick();

    // Write then read-after-write from the other requester.
    set_req(0, 1, 1, 4'd3, 8'hA5);
    #1 chk("wr_ready", 32'(req_ready), 32'h1);
    tick();
    chk("wr_no_rsp", 32'(rsp_valid), 0);
    clear();
    set_req(1, 1, 0, 4'd3, 8'h00);
    #1 chk("raw_ready", 32'(req_ready), 32'h2);
    tick();
    chk("raw_valid", 32'(rsp_valid), 32'h2);
    chk("raw_data", 32'(rsp_rdata), 32'hA5);
    clear();

    // Distinct data at addr 1 and 2, then contending reads alternate.
    set_req(0, 1, 1, 4'd1, 8'h3C);
    tick();
    clear();
    set_req(1, 1, 1, 4'd2, 8'hC3);
    tick();
    clear();
    set_req(0, 1, 0, 4'd1, 8'h00);
    set_req(1, 1, 0, 4'd2, 8'h00);
    for (int k = 0; k < 4; k++) begin
      #1 chk("alt_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("alt_valid", 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_data", 32'(rsp_rdata), (k % 2 == 0) ? 32'h3C : 32'hC3);
    end
    clear();

    // Move pointer to requester 1, then conflicting write/read on addr 5.
    set_req(0, 1, 0, 4'd0, 8'h00);
    tick();
    clear();
    set_req(0, 1, 1, 4'd5, 8'h11);
    set_req(1, 1, 0, 4'd5, 8'h00);
    #1 chk("conf_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("conf_rd_valid", 32'(rsp_valid), 32'h2);
    chk("conf_rd_old", 32'(rsp_rdata), 32'h00);
    set_req(1, 0, 0, 4'd0, 8'h00);
    #1 chk("conf_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("conf_wr_no_rsp", 32'(rsp_valid), 0);
    clear();
    set_req(1, 1, 0, 4'd5, 8'h00);
    tick();
    chk("conf_rd_new", 32'(rsp_rdata), 32'h11);
    clear();
    tick();

    // Reset during the sweep at counter 7.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (7) tick();
    chk("mid_init_addr7", 32'(ram_addr), 7);
    rst = 1'b0;
    tick();
    chk("mid_init_restart", 32'(ram_addr), 0);
    chk("mid_init_done0", 32'(init_done), 0);
    rst = 1'b1;
    repeat (15) tick();
    chk("mid_init_still0", 32'(init_done), 0);
    tick();
    chk("mid_init_done1", 32'(init_done), 1);

    // Reset in ARB the cycle after a read is accepted.
    set_req(0, 1, 1, 4'd3, 8'hA5);
    tick();
    clear();
    set_req(0, 1, 0, 4'd3, 8'h00);
    tick();
    chk("arb_rst_pre_valid", 32'(rsp_valid), 32'h1);
    chk("arb_rst_pre_data", 32'(rsp_rdata), 32'hA5);
    clear();
    rst = 1'b0;
    tick();
    chk("arb_rst_valid0", 32'(rsp_valid), 0);
    chk("arb_rst_done0", 32'(init_done), 0);
    rst = 1'b1;
    repeat (16) tick();
    chk("arb_rst_done1", 32'(init_done), 1);
    for (int a = 0; a < DEPTH; a++) begin
      clear();
      set_req(1, 1, 0, AW'(a), 8'h00);
      tick();
      chk("rerun_rd_valid", 32'(rsp_valid), 32'h2);
      chk("rerun_rd_data", 32'(rsp_rdata), 32'(INIT));
    end
    clear();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
